// File: rtl/uart_term_wr_arbiter_pkg.sv
// Shared terminal definitions plus arbiter state encoding for uart_term_wr_arbiter.
// Also the home of the clog2 helper used for index widths.
package uart_term_wr_arbiter_pkg;

  localparam int TERM_DW = 8;
  localparam int TERM_AW = 8;
  localparam logic [7:0] TERM_EOF = 8'hFF;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } arb_state_e;

  // Minimum result of 1 keeps index vectors legal for tiny configurations.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/uart_term_wr_arbiter_if.sv
// Producer-side request bundle and handler-side write channel of the terminal write arbiter.
// Handshake: a beat moves on a clock edge where valid & ready are both high; the source holds
//   valid/data/addr/last stable until it sees ready, and ready never waits on anything but the sink.
interface uart_term_wr_arbiter_if
  import uart_term_wr_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DW      = TERM_DW,
  parameter int AW      = TERM_AW
);

  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ*DW-1:0] req_data;
  logic [NUM_REQ*AW-1:0] req_addr;
  logic [NUM_REQ-1:0]    req_last;
  logic [NUM_REQ-1:0]    req_ready;

  logic                  w_valid;
  logic                  w_ready;
  logic [DW-1:0]         w_data;
  logic [AW-1:0]         w_addr;
  logic                  w_last;

  // master: the arbiter, driving the handler write port and producer readies
  modport master (
    input  req_valid, req_data, req_addr, req_last, w_ready,
    output req_ready, w_valid, w_data, w_addr, w_last
  );

  // slave: the producers and the terminal handler around the arbiter
  modport slave (
    output req_valid, req_data, req_addr, req_last, w_ready,
    input  req_ready, w_valid, w_data, w_addr, w_last
  );

endinterface

// File: rtl/uart_term_rr_pick.sv
// Combinational round-robin picker: first asserted request strictly after ptr, wrapping,
// so the requester at ptr itself is considered last.
module uart_term_rr_pick
  import uart_term_wr_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  localparam int IW = clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IW-1:0]      ptr_i,
  output logic               any_o,
  output logic [IW-1:0]      idx_o
);

  int   pos;
  logic found;

  assign any_o = |req_i;

  always_comb begin
    idx_o = '0;
    found = 1'b0;
    pos   = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      pos = int'(ptr_i) + k;
      if (pos >= NUM_REQ) pos = pos - NUM_REQ;
      if (!found && req_i[pos[IW-1:0]]) begin
        idx_o = pos[IW-1:0];
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_term_wr_arbiter.sv
// Round-robin whole-message arbiter in front of the uart_terminal_handler write port.
// Optional stalled-grantee release is built with `define ARB_TIMEOUT_EN.
module uart_term_wr_arbiter
  import uart_term_wr_arbiter_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int DW          = TERM_DW,
  parameter int AW          = TERM_AW,
  parameter int TIMEOUT_CYC = 1024,
  localparam int IW = clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  uart_term_wr_arbiter_if.master    bus,
  output logic                      busy,
  output logic [IW-1:0]             grant_id,
  output logic                      err_timeout,
  output arb_state_e                dbg_state
);

  arb_state_e    state_q, state_d;
  logic [IW-1:0] grant_q, grant_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [IW-1:0] pick_idx;
  logic          pick_any;
  logic          g_valid, g_last, beat, tmo_hit;
  logic [DW-1:0] g_data;
  logic [AW-1:0] g_addr;

  uart_term_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req_i (bus.req_valid),
    .ptr_i (ptr_q),
    .any_o (pick_any),
    .idx_o (pick_idx)
  );

  assign g_valid = bus.req_valid[grant_q];
  assign g_last  = bus.req_last[grant_q];
  assign g_data  = bus.req_data[grant_q*DW +: DW];
  assign g_addr  = bus.req_addr[grant_q*AW +: AW];
  assign beat    = (state_q == ST_BURST) && g_valid && bus.w_ready;

`ifdef ARB_TIMEOUT_EN
  localparam int CW = clog2(TIMEOUT_CYC) + 1;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;

  assign tmo_hit = (state_q == ST_BURST) && !g_valid && (cnt_q == CW'(TIMEOUT_CYC - 1));

  // Counter sits at zero throughout IDLE, so every BURST entry starts clean.
  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q;
    if (state_q == ST_IDLE || beat) begin
      cnt_d = '0;
    end else if (!g_valid) begin
      if (tmo_hit) begin
        cnt_d = '0;
        err_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign err_timeout = rst_n && err_q;
`else
  assign tmo_hit     = 1'b0;
  assign err_timeout = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          grant_d = pick_idx;
          state_d = ST_BURST;
        end
      end
      ST_BURST: begin
        if ((beat && g_last) || tmo_hit) begin
          ptr_d   = grant_q;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      ptr_q   <= IW'(NUM_REQ - 1);
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
    end
  end

  // Outputs are forced low while rst_n is held, not just after the reset edge.
  always_comb begin
    bus.w_valid   = 1'b0;
    bus.w_data    = '0;
    bus.w_addr    = '0;
    bus.w_last    = 1'b0;
    bus.req_ready = '0;
    if (rst_n && state_q == ST_BURST) begin
      bus.w_valid            = g_valid;
      bus.w_data             = g_data;
      bus.w_addr             = g_addr;
      bus.w_last             = g_last;
      bus.req_ready[grant_q] = bus.w_ready;
    end
  end

  assign busy      = rst_n && (state_q == ST_BURST);
  assign grant_id  = rst_n ? grant_q : '0;
  assign dbg_state = rst_n ? state_q : ST_IDLE;

endmodule

// File: tb/tb_uart_term_wr_arbiter.sv
// Self-checking bench for uart_term_wr_arbiter: per-requester message drivers, a beat
// scoreboard on the handler side, and directed arbitration/reset/timeout scenarios.
module tb_uart_term_wr_arbiter;
  import uart_term_wr_arbiter_pkg::*;

  localparam int NUM_REQ = 4;
  localparam int DW      = 8;
  localparam int AW      = 8;
  localparam int IW      = 2;
  localparam int TMO     = 16;
  localparam int BOUND   = 200;
  localparam int W       = IW + 1 + AW + DW;

  // clock / reset
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          busy;
  logic          err_timeout;
  logic [IW-1:0] grant_id;
  arb_state_e    dbg_state;

  uart_term_wr_arbiter_if #(.NUM_REQ(NUM_REQ), .DW(DW), .AW(AW)) bus ();

  uart_term_wr_arbiter #(
    .NUM_REQ(NUM_REQ), .DW(DW), .AW(AW), .TIMEOUT_CYC(TMO)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus.master),
    .busy        (busy),
    .grant_id    (grant_id),
    .err_timeout (err_timeout),
    .dbg_state   (dbg_state)
  );

  int          checks   = 0;
  int          failures = 0;
  logic [W-1:0] exp_q[$];
  int          gap_q[$];
  bit          rnd_ready = 1'b0;
  int          exp_ptr   = NUM_REQ - 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // message content model
  function automatic logic [DW-1:0] beat_data(input int id, input int k, input int n);
    if (k == n - 1) return TERM_EOF;
    return 8'h41 + DW'(((id + 3) % NUM_REQ) * 6 + k);
  endfunction

  function automatic logic [AW-1:0] beat_addr(input int id, input int k);
    return AW'(8'h70 + id * 16 + k);
  endfunction

  function automatic logic [W-1:0] beat_word(input int id, input int k, input int n);
    return {IW'(id), (k == n - 1), beat_addr(id, k), beat_data(id, k, n)};
  endfunction

  task automatic push_msg(input int id, input int n);
    for (int k = 0; k < n; k++) exp_q.push_back(beat_word(id, k, n));
  endtask

  // driver: one requester, n beats, each held until accepted
  task automatic send_msg(input int id, input int n);
    bit rdy;
    int cyc;
    for (int k = 0; k < n; k++) begin
      bus.req_data[id*DW +: DW] = beat_data(id, k, n);
      bus.req_addr[id*AW +: AW] = beat_addr(id, k);
      bus.req_last[id]          = (k == n - 1);
      bus.req_valid[id]         = 1'b1;
      cyc = 0;
      do begin
        @(negedge clk);
        rdy = bus.req_ready[id];
        @(posedge clk);
        #1;
        cyc++;
      end while (!rdy && cyc < BOUND);
      if (!rdy) begin
        check($sformatf("send_tmo_r%0d", id), 32'(rdy), 32'd1);
        break;
      end
    end
    bus.req_valid[id] = 1'b0;
    bus.req_last[id]  = 1'b0;
  endtask

  always @(posedge clk) begin
    #1;
    if (rnd_ready) bus.w_ready = 1'($urandom_range(0, 1));
  end

  // scoreboard monitor and inter-message idle-gap tracker
  int   idle_run  = 0;
  logic prev_busy = 1'b0;
  always @(negedge clk) begin
    if (rst_n && bus.w_valid && bus.w_ready) begin
      if (exp_q.size() == 0) check("unexpected_beat", 32'(exp_q.size()), 32'd1);
      else check("beat", 32'({grant_id, bus.w_last, bus.w_addr, bus.w_data}), 32'(exp_q.pop_front()));
    end
    if (rst_n) begin
      if (busy && !prev_busy) begin
        gap_q.push_back(idle_run);
        idle_run = 0;
      end else if (!busy) begin
        idle_run++;
      end
      prev_busy = busy;
    end
  end

  task automatic drained(input string tag);
    check(tag, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    logic [3:0] pat;
    int len[NUM_REQ];

    bus.req_valid = '0;
    bus.req_last  = '0;
    bus.req_data  = '0;
    bus.req_addr  = '0;
    bus.w_ready   = 1'b1;

    // reset
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_w_valid", 32'(bus.w_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_grant", 32'(grant_id), 32'd0);
    check("rst_err", 32'(err_timeout), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_state", 32'(dbg_state), 32'(ST_IDLE));
    check("post_rst_grant", 32'(grant_id), 32'd0);
    @(posedge clk);
    #1;

    // simultaneous 0,2,3 from reset pointer: order 0,2,3 with one idle cycle between
    gap_q.delete();
    push_msg(0, 2); push_msg(2, 2); push_msg(3, 2);
    fork
      send_msg(0, 2);
      send_msg(2, 2);
      send_msg(3, 2);
    join
    check("t2_gap_count", 32'(gap_q.size()), 32'd3);
    if (gap_q.size() == 3) begin
      check("t2_gap1", 32'(gap_q[1]), 32'd1);
      check("t2_gap2", 32'(gap_q[2]), 32'd1);
    end
    drained("t2_drain");
    exp_ptr = 3;

    // requester 1: "A","B",EOF at 0x80..0x82, back-to-back, grant after one cycle
    push_msg(1, 3);
    fork
      send_msg(1, 3);
      begin
        @(negedge clk);
        check("t1_lat_busy", 32'(busy), 32'd0);
        @(negedge clk);
        check("t1_busy", 32'(busy), 32'd1);
        check("t1_grant", 32'(grant_id), 32'd1);
        check("t1_beat0_v", 32'(bus.w_valid), 32'd1);
        @(negedge clk);
        check("t1_beat1_v", 32'(bus.w_valid), 32'd1);
        @(negedge clk);
        check("t1_beat2_last", 32'({bus.w_valid, bus.w_last, bus.w_addr}), 32'({2'b11, 8'h82}));
      end
    join
    @(negedge clk);
    check("t1_busy_drop", 32'(busy), 32'd0);
    @(posedge clk);
    #1;
    drained("t1_drain");
    exp_ptr = 1;

    // requester 2 joins mid-way through requester 1's message
    push_msg(1, 4); push_msg(2, 2);
    fork
      send_msg(1, 4);
      begin
        repeat (2) @(posedge clk);
        #1;
        fork
          send_msg(2, 2);
          begin
            c = 0;
            do begin
              @(negedge clk);
              c++;
              if (busy && grant_id == 1) check("t4_r2_blocked", 32'(bus.req_ready[2]), 32'd0);
            end while (busy && grant_id == 1 && c < BOUND);
          end
        join
      end
    join
    drained("t4_drain");
    exp_ptr = 2;

    // grantee 0 with w_ready 1,0,0,1
    push_msg(0, 2);
    pat = 4'b1001;
    bus.w_ready = 1'b0;
    fork
      send_msg(0, 2);
      begin
        c = 0;
        do begin
          @(negedge clk);
          c++;
        end while (!busy && c < BOUND);
        check("t3_busy", 32'(busy), 32'd1);
        for (int k = 0; k < 4; k++) begin
          @(posedge clk);
          #1 bus.w_ready = pat[3-k];
          @(negedge clk);
          check($sformatf("t3_ready_mirror%0d", k), 32'(bus.req_ready[0]), 32'(pat[3-k]));
          if (k > 0) check($sformatf("t3_hold%0d", k), 32'(bus.w_data), 32'(TERM_EOF));
        end
      end
    join
    bus.w_ready = 1'b1;
    drained("t3_drain");
    exp_ptr = 0;

    // reset on the 2nd beat of requester 1's message; requester 0 must win afterwards
    exp_q.push_back(beat_word(1, 0, 3));
    bus.req_data[1*DW +: DW] = beat_data(1, 0, 3);
    bus.req_addr[1*AW +: AW] = beat_addr(1, 0);
    bus.req_last[1]          = 1'b0;
    bus.req_valid[1]         = 1'b1;
    @(negedge clk);
    check("t5_idle", 32'(busy), 32'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("t5_grant1", 32'({bus.w_valid, grant_id}), 32'({1'b1, 2'd1}));
    @(posedge clk);
    #1;
    bus.req_data[1*DW +: DW] = beat_data(1, 1, 3);
    bus.req_addr[1*AW +: AW] = beat_addr(1, 1);
    rst_n = 1'b0;
    @(negedge clk);
    check("t5_rst_w_valid", 32'(bus.w_valid), 32'd0);
    check("t5_rst_busy", 32'(busy), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus.req_valid[1] = 1'b0;
    @(negedge clk);
    check("t5_after_busy", 32'(busy), 32'd0);
    check("t5_after_w_valid", 32'(bus.w_valid), 32'd0);
    check("t5_after_grant", 32'(grant_id), 32'd0);
    @(posedge clk);
    #1;
    push_msg(0, 1); push_msg(1, 3);
    fork
      send_msg(0, 1);
      send_msg(1, 3);
    join
    drained("t5_drain");
    exp_ptr = 1;

`ifdef ARB_TIMEOUT_EN
    // grantee 2 stalls after its first beat; forced release after TMO stalled cycles
    exp_q.push_back(beat_word(2, 0, 4));
    push_msg(3, 1);
    fork
      send_msg(3, 1);
      begin
        bus.req_data[2*DW +: DW] = beat_data(2, 0, 4);
        bus.req_addr[2*AW +: AW] = beat_addr(2, 0);
        bus.req_last[2]          = 1'b0;
        bus.req_valid[2]         = 1'b1;
        c = 0;
        do begin
          @(negedge clk);
          pat[0] = bus.req_ready[2];
          @(posedge clk);
          #1;
          c++;
        end while (!pat[0] && c < BOUND);
        check("t6_beat0", 32'(pat[0]), 32'd1);
        bus.req_valid[2] = 1'b0;
        repeat (TMO) @(negedge clk);
        check("t6_hold_busy", 32'(busy), 32'd1);
        check("t6_hold_err", 32'(err_timeout), 32'd0);
        @(negedge clk);
        check("t6_rel_busy", 32'(busy), 32'd0);
        check("t6_rel_err", 32'(err_timeout), 32'd1);
      end
    join
    drained("t6_drain");
    check("t6_err_sticky", 32'(err_timeout), 32'd1);
    exp_ptr = 3;
`endif

    // all four requesters, random lengths, random w_ready
    for (int i = 0; i < NUM_REQ; i++) len[i] = $urandom_range(1, 4);
    for (int i = 0; i < NUM_REQ; i++) push_msg((exp_ptr + 1 + i) % NUM_REQ, len[(exp_ptr + 1 + i) % NUM_REQ]);
    rnd_ready = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) begin
      automatic int id = i;
      automatic int n  = len[i];
      fork
        send_msg(id, n);
      join_none
    end
    wait fork;
    rnd_ready = 1'b0;
    @(posedge clk);
    #2 bus.w_ready = 1'b1;
    drained("t7_drain");

`ifndef ARB_TIMEOUT_EN
    check("err_tied_low", 32'(err_timeout), 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
